// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: during hblank copies the frog/car sprite rows for the next
// scanline into line buffers, then composites frog > car > background per pixel.
module sprite_line_fetcher #(
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter logic [8:0]  TRANSPARENT = 9'b111000111,
  parameter logic [8:0]  BG_COLOR    = 9'h000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_line_start,
  input  logic [9:0] i_next_row,
  input  logic [9:0] i_frog_x,
  input  logic [9:0] i_frog_y,
  input  logic [9:0] i_car_x,
  input  logic [9:0] i_car_y,
  input  logic       i_active,
  input  logic [9:0] i_col,
  output logic       o_read_en,
  output logic [9:0] o_read_addr,
  output logic       o_mem_select,
  input  logic [8:0] i_read_data,
  output logic [8:0] o_pixel,
  output logic       o_pixel_valid,
  output logic       o_busy,
  output logic       o_overrun
);
  localparam int KW = $clog2(SPRITE_W);
  localparam logic [KW-1:0] K_LAST = KW'(SPRITE_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH_FROG, FETCH_CAR, DRAIN} state_t;

  state_t        state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic [9:0]    frog_x, car_x, frog_off, car_off;
  logic          frog_lv, car_lv;
  logic          cap_en, cap_sel;
  logic [KW-1:0] cap_k;
  logic [8:0]    frog_buf [SPRITE_W];
  logic [8:0]    car_buf  [SPRITE_W];

  // Row hit test for the incoming line_start
  logic [9:0] frog_dy, car_dy;
  logic       frog_rhit, car_rhit;
  assign frog_dy   = i_next_row - i_frog_y;
  assign car_dy    = i_next_row - i_car_y;
  assign frog_rhit = (i_next_row >= i_frog_y) && (frog_dy < 10'(SPRITE_H));
  assign car_rhit  = (i_next_row >= i_car_y)  && (car_dy  < 10'(SPRITE_H));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state     <= IDLE;
      k         <= '0;
      frog_x    <= '0;
      car_x     <= '0;
      frog_off  <= '0;
      car_off   <= '0;
      frog_lv   <= 1'b0;
      car_lv    <= 1'b0;
      o_overrun <= 1'b0;
      cap_en    <= 1'b0;
      cap_sel   <= 1'b0;
      cap_k     <= '0;
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      cap_en  <= o_read_en;
      cap_sel <= o_mem_select;
      cap_k   <= k;
      if (i_line_start) begin
        frog_x   <= i_frog_x;
        car_x    <= i_car_x;
        frog_off <= frog_dy;
        car_off  <= car_dy;
        frog_lv  <= frog_rhit;
        car_lv   <= car_rhit;
        if (state != IDLE) o_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    k_nx         = k;
    o_read_en    = 1'b0;
    o_mem_select = 1'b0;
    o_read_addr  = '0;
    case (state)
      FETCH_FROG: begin
        o_read_en   = 1'b1;
        o_read_addr = 10'(frog_off * SPRITE_W) + 10'(k);
        k_nx        = k + KW'(1);
        if (k == K_LAST) begin
          k_nx     = '0;
          state_nx = car_lv ? FETCH_CAR : DRAIN;
        end
      end
      FETCH_CAR: begin
        o_read_en    = 1'b1;
        o_mem_select = 1'b1;
        o_read_addr  = 10'(car_off * SPRITE_W) + 10'(k);
        k_nx         = k + KW'(1);
        if (k == K_LAST) begin
          k_nx     = '0;
          state_nx = DRAIN;
        end
      end
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A new line always wins, aborting any fetch in flight
    if (i_line_start) begin
      k_nx     = '0;
      state_nx = frog_rhit ? FETCH_FROG : (car_rhit ? FETCH_CAR : IDLE);
    end
  end

  assign o_busy = (state != IDLE);

  // Memory data returns one cycle after the read, so select/k are delayed to match
  always_ff @(posedge i_Clk) begin
    if (!i_Reset && cap_en) begin
      if (cap_sel) car_buf[cap_k]  <= i_read_data;
      else         frog_buf[cap_k] <= i_read_data;
    end
  end

  logic [9:0] frog_dx, car_dx;
  logic       frog_op, car_op;
  logic [8:0] frog_px, car_px;
  assign frog_dx = i_col - frog_x;
  assign car_dx  = i_col - car_x;
  assign frog_px = frog_buf[frog_dx[KW-1:0]];
  assign car_px  = car_buf[car_dx[KW-1:0]];
  assign frog_op = frog_lv && (i_col >= frog_x) && (frog_dx < 10'(SPRITE_W)) && (frog_px != TRANSPARENT);
  assign car_op  = car_lv  && (i_col >= car_x)  && (car_dx  < 10'(SPRITE_W)) && (car_px  != TRANSPARENT);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
    end else begin
      o_pixel_valid <= i_active;
      if (!i_active)    o_pixel <= BG_COLOR;
      else if (frog_op) o_pixel <= frog_px;
      else if (car_op)  o_pixel <= car_px;
      else              o_pixel <= BG_COLOR;
    end
  end
endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Scoreboard bench for sprite_line_fetcher: expected reads and pixels are queued at
// stimulus time and a negedge monitor compares them as the DUT presents outputs.
module tb_sprite_line_fetcher;
  localparam logic [8:0] T  = 9'b111000111;
  localparam int         BG = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_start = 1'b0;
  logic [9:0] next_row = '0, frog_x = '0, frog_y = '0, car_x = '0, car_y = '0;
  logic       active = 1'b0;
  logic [9:0] col = '0;
  logic       read_en, mem_select, pixel_valid, busy, overrun;
  logic [9:0] read_addr;
  logic [8:0] read_data = '0, pixel;

  always #5 clk = ~clk;

  sprite_line_fetcher dut (
    .i_Clk(clk), .i_Reset(rst), .i_line_start(line_start), .i_next_row(next_row),
    .i_frog_x(frog_x), .i_frog_y(frog_y), .i_car_x(car_x), .i_car_y(car_y),
    .i_active(active), .i_col(col), .o_read_en(read_en), .o_read_addr(read_addr),
    .o_mem_select(mem_select), .i_read_data(read_data), .o_pixel(pixel),
    .o_pixel_valid(pixel_valid), .o_busy(busy), .o_overrun(overrun)
  );

  logic [8:0] frog_mem [1024];
  logic [8:0] car_mem  [1024];
  always @(posedge clk) if (read_en) read_data <= mem_select ? car_mem[read_addr] : frog_mem[read_addr];

  int n_cmp = 0, n_bad = 0;
  int rd_q[$];
  int pix_q[$];
  bit mon_on = 1'b0;

  // Reference view of the current line: which sprites cover it and where
  int m_row, m_fx, m_fy, m_cx, m_cy;
  bit m_fv = 1'b0, m_cv = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_pix(input int c);
    int v;
    if (m_fv && c >= m_fx && c < m_fx + 32) begin
      v = frog_mem[(m_row - m_fy) * 32 + (c - m_fx)];
      if (v != T) return v;
    end
    if (m_cv && c >= m_cx && c < m_cx + 32) begin
      v = car_mem[(m_row - m_cy) * 32 + (c - m_cx)];
      if (v != T) return v;
    end
    return BG;
  endfunction

  always @(negedge clk) if (mon_on) begin
    if (read_en) begin
      if (rd_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL read_unexpected: got sel %0d addr %0d expected no read", mem_select, read_addr);
      end else begin
        int e;
        e = rd_q.pop_front();
        check("read_sel", int'(mem_select), e >> 10);
        check("read_addr", int'(read_addr), e & 1023);
      end
    end
    if (pixel_valid) begin
      if (pix_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pixel_unexpected: got %0d expected no pixel", pixel);
      end else check("pixel", int'(pixel), pix_q.pop_front());
    end else check("pixel_idle_bg", int'(pixel), BG);
  end

  // Called at posedge+1; returns at the following posedge+1
  task automatic start_line(input int row, fx, fy, cx, cy, input int limit);
    int n = 0;
    m_row = row; m_fx = fx; m_fy = fy; m_cx = cx; m_cy = cy;
    m_fv = (row >= fy) && (row < fy + 32);
    m_cv = (row >= cy) && (row < cy + 32);
    if (m_fv) for (int k = 0; k < 32; k++) if (limit < 0 || n < limit) begin
      rd_q.push_back((row - fy) * 32 + k); n++;
    end
    if (m_cv) for (int k = 0; k < 32; k++) if (limit < 0 || n < limit) begin
      rd_q.push_back(1024 + (row - cy) * 32 + k); n++;
    end
    next_row = 10'(row); frog_x = 10'(fx); frog_y = 10'(fy); car_x = 10'(cx); car_y = 10'(cy);
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_fetch();
    int c = 0, nh;
    nh = int'(m_fv) + int'(m_cv);
    repeat (80) begin @(negedge clk); if (busy) c++; end
    check("busy_cycles", c, nh == 0 ? 0 : nh * 32 + 1);
    @(posedge clk); #1;
  endtask

  task automatic show_line();
    for (int c = 0; c < 1024; c++) begin
      active = 1'b1; col = 10'(c);
      pix_q.push_back(ref_pix(c));
      @(posedge clk); #1;
    end
    active = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic run_line(input int row, fx, fy, cx, cy);
    start_line(row, fx, fy, cx, cy, -1);
    wait_fetch();
    show_line();
  endtask

  initial begin
    int row, fx, fy, cx, cy;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_en", int'(read_en), 0);
    check("rst_pixel", int'(pixel), 0);
    check("rst_pixel_valid", int'(pixel_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      frog_mem[i] = ($urandom_range(0, 3) == 0) ? T : 9'($urandom);
      car_mem[i]  = ($urandom_range(0, 3) == 0) ? T : 9'($urandom);
    end

    run_line(53, 100, 50, 600, 400);           // frog only
    frog_mem[175] = T;                         // frog transparent at col 115 of row 55
    run_line(55, 100, 50, 110, 40);
    frog_mem[175] = 9'h0AA;                    // now opaque
    run_line(55, 100, 50, 110, 40);
    run_line(81, 100, 50, 600, 400);           // last frog row
    run_line(82, 100, 50, 600, 400);           // just past it: no fetch

    // Second line_start ten reads into a fetch
    start_line(53, 100, 50, 600, 400, 10);
    repeat (9) @(posedge clk);
    #1;
    start_line(60, 200, 40, 210, 45, -1);
    wait_fetch();
    check("overrun_set", int'(overrun), 1);
    show_line();
    run_line(70, 300, 60, 900, 900);
    check("overrun_sticky", int'(overrun), 1);

    // Reset twenty reads into a fetch
    start_line(53, 100, 50, 110, 40, 20);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_read_en", int'(read_en), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_overrun", int'(overrun), 0);
    rst = 1'b0;
    m_fv = 1'b0; m_cv = 1'b0;
    @(posedge clk); #1;
    show_line();

    repeat (8) begin
      row = $urandom_range(0, 479);
      fy  = row - int'($urandom_range(0, 40)); if (fy < 0) fy = 0;
      cy  = row - int'($urandom_range(0, 40)); if (cy < 0) cy = 0;
      fx  = $urandom_range(0, 1023);
      cx  = fx + int'($urandom_range(0, 40)) - 20;
      if (cx < 0) cx = 0;
      if (cx > 1023) cx = 1023;
      run_line(row, fx, fy, cx, cy);
    end

    repeat (3) @(negedge clk);
    check("read_q_empty", rd_q.size(), 0);
    check("pix_q_empty", pix_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
